// File: rtl/ram_pkg.sv
// Shared defaults and word/address types for the ram storage primitive.
// Widths here are defaults only; instances may override them by parameter.
package ram_pkg;

  localparam int RAM_ADDR_WIDTH_DEF = 4;
  localparam int RAM_DATA_WIDTH_DEF = 8;

  typedef logic [RAM_ADDR_WIDTH_DEF-1:0] ram_addr_t;
  typedef logic [RAM_DATA_WIDTH_DEF-1:0] ram_data_t;

  function automatic int ram_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/ram_storage.sv
// Clearable word array with one write port and a combinational lookup port.
// Write lands on the enabled rising edge; no backpressure, accepts every cycle.
module ram_storage
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_word
);

  localparam int DEPTH = ram_depth(ADDR_WIDTH);

  // Packed so the whole array clears in one reset assignment.
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
    end else if (wr_enb) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_word = mem[rd_addr];

endmodule

// File: rtl/ram.sv
// Two-port synchronous RAM: registered read, one-cycle latency, write-first on collision.
// No handshake or backpressure; reads and writes may issue every cycle.
module ram
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  generate
    if (ADDR_WIDTH < 1 || DATA_WIDTH < 1) begin : g_bad_width
      $error("ram: ADDR_WIDTH and DATA_WIDTH must both be at least 1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_word;
  logic [DATA_WIDTH-1:0] rd_next;
  logic                  collide;

  ram_storage #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .wr_enb  (wr_enb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_word (mem_word)
  );

  // The array still holds the old word on a same-edge collision, so bypass it.
  always_comb begin
    collide = wr_enb && (wr_addr == rd_addr);
    rd_next = collide ? wr_data : mem_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_enb) begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: constant vector table, directed corner sequences,
// and random traffic checked against an array-based reference model.
module tb_ram;
  import ram_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      wr_enb;
  ram_addr_t wr_addr;
  ram_data_t wr_data;
  logic      rd_enb;
  ram_addr_t rd_addr;
  ram_data_t rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  ram_data_t ref_mem[16];
  ram_data_t ref_rd;

  typedef struct {
    logic      we;
    ram_addr_t wa;
    ram_data_t wd;
    logic      re;
    ram_addr_t ra;
    ram_data_t exp;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  ram u_dut (
    .clk     (clk),
    .rst     (rst),
    .wr_enb  (wr_enb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_enb  (rd_enb),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  task automatic chk(input string nm, input ram_data_t act, input ram_data_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: rd_data=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    ref_rd = '0;
  endtask

  // Drive one cycle of stimulus, advance the model by the read/write rules,
  // and return 1 time unit after the rising edge.
  task automatic cycle(input logic we, input ram_addr_t wa, input ram_data_t wd,
                       input logic re, input ram_addr_t ra);
    wr_enb  = we;
    wr_addr = wa;
    wr_data = wd;
    rd_enb  = re;
    rd_addr = ra;
    if (re) ref_rd = (we && wa == ra) ? wd : ref_mem[ra];
    if (we) ref_mem[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'h9, 8'hA6, 1'b0, 4'h0, 8'h00};
    vecs[1]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h9, 8'hA6};
    vecs[2]  = '{1'b1, 4'h3, 8'h55, 1'b0, 4'h3, 8'hA6};
    vecs[3]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h3, 8'h55};
    vecs[4]  = '{1'b1, 4'h5, 8'h11, 1'b1, 4'h2, 8'h00};
    vecs[5]  = '{1'b1, 4'h5, 8'h22, 1'b1, 4'h5, 8'h22};
    vecs[6]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h5, 8'h22};
    vecs[7]  = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h22};
    vecs[8]  = '{1'b1, 4'h0, 8'hFF, 1'b1, 4'h0, 8'hFF};
    vecs[9]  = '{1'b1, 4'hF, 8'h80, 1'b1, 4'h3, 8'h55};
    vecs[10] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 8'h80};

    rst = 1'b0; wr_enb = 1'b0; wr_addr = '0; wr_data = '0; rd_enb = 1'b0; rd_addr = '0;
    model_clear();
    #12;
    chk("reset_state", rd_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Constant vector table
    foreach (vecs[i]) begin
      cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
      chk($sformatf("vec%0d", i), rd_data, vecs[i].exp);
    end

    // Hold: read 0x3 (0x55), then rd_enb low for 3 cycles while rd_addr moves
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'h3);
    chk("hold_load", rd_data, 8'h55);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'h0, 8'h00, 1'b0, ram_addr_t'(i + 7));
      chk($sformatf("hold%0d", i), rd_data, 8'h55);
    end

    // Collision: 0x5 holds 0x11; write 0x22 while reading 0x5 on the same edge
    cycle(1'b1, 4'h5, 8'h11, 1'b0, 4'h0);
    cycle(1'b1, 4'h5, 8'h22, 1'b1, 4'h5);
    chk("collide_bypass", rd_data, 8'h22);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'h5);
    chk("collide_mem", rd_data, 8'h22);

    // Reset clear: write 0xA6 to 0x9, pulse rst for one cycle, read 0x9
    cycle(1'b1, 4'h9, 8'hA6, 1'b1, 4'h9);
    chk("pre_reset_rd", rd_data, 8'hA6);
    wr_enb = 1'b0; rd_enb = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_async_clear", rd_data, 8'h00);
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_held", rd_data, 8'h00);
    rst = 1'b1;
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'h9);
    chk("rst_cleared_mem", rd_data, 8'h00);

    // Write then read
    cycle(1'b1, 4'h9, 8'hA6, 1'b0, 4'h0);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'h9);
    chk("wr_then_rd", rd_data, 8'hA6);

    // Ten random writes, ten random reads against the model
    for (int i = 0; i < 10; i++)
      cycle(1'b1, ram_addr_t'($urandom_range(15)), ram_data_t'($urandom), 1'b0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 4'h0, 8'h00, 1'b1, ram_addr_t'($urandom_range(15)));
      chk($sformatf("rand_rd%0d", i), rd_data, ref_rd);
    end

    // Mixed random traffic with frequent collisions
    for (int i = 0; i < 60; i++) begin
      automatic ram_addr_t ra = ram_addr_t'($urandom_range(15));
      automatic ram_addr_t wa = ($urandom_range(3) == 0) ? ra : ram_addr_t'($urandom_range(15));
      cycle(1'($urandom_range(1)), wa, ram_data_t'($urandom), 1'($urandom_range(1)), ra);
      chk($sformatf("mix%0d", i), rd_data, ref_rd);
    end

    // Async reset mid-burst
    cycle(1'b1, 4'h1, 8'h3C, 1'b1, 4'h1);
    chk("burst_rd", rd_data, 8'h3C);
    cycle(1'b1, 4'h2, 8'h4D, 1'b0, 4'h0);
    wr_enb = 1'b1; wr_addr = 4'h3; wr_data = 8'h5E;
    #3;
    rst = 1'b0;
    #1;
    chk("burst_rst_drop", rd_data, 8'h00);
    model_clear();
    @(posedge clk);
    #2;
    chk("burst_rst_hold", rd_data, 8'h00);
    wr_enb = 1'b0;
    rst = 1'b1;
    for (int a = 0; a < 16; a++) begin
      cycle(1'b0, 4'h0, 8'h00, 1'b1, ram_addr_t'(a));
      chk($sformatf("post_rst_a%0d", a), rd_data, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
